micro_simd_wb_stage: RTL and testbench
======================================

// Module: micro_simd_wb_stage
// PURPOSE
//  Writeback/commit stage directly downstream of the 8-lane x 4-bit micro-SIMD ALU.
//  Captures the combinational ALU result (32b) and per-lane flags (32b, lane k = {N,Z,C,V}
//  at bits [4k+3:4k]) into a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//  At commit it drives the Thumb low-register-file write port and updates the sticky
//  per-lane GE and Q state. Sits between the SIMD execute stage and the M0 register file.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of two, 2..16
//  RD_W   3  destination register index width (r0-r7)
// PORTS
//  i_CLK        in   1     clock, all state updates on rising edge
//  i_RST        in   1     synchronous reset, active-high
//  i_VALID      in   1     execute stage presents a result this cycle
//  o_READY      out  1     stage accepts a result this cycle (= !full)
//  i_RES        in   32    SIMD result from ALU
//  i_FLAGS      in   32    per-lane flags from ALU, {N,Z,C,V} per nibble
//  i_RD         in   RD_W  destination register
//  i_FLAG_UPD   in   1     result updates sticky GE/Q state when committed
//  i_FLUSH      in   1     discard all buffered, uncommitted entries
//  i_Q_CLR      in   1     clear sticky Q
//  o_WB_VALID   out  1     head entry valid for register-file write
//  i_WB_READY   in   1     register file accepts write this cycle
//  o_WB_DATA    out  32    head entry result
//  o_WB_RD      out  RD_W  head entry destination
//  o_GE         out  8     sticky lane GE bits (lane k = C bit of last updating commit)
//  o_Q          out  1     sticky saturation: OR of V bits of all updating commits since clear
//  o_LANE_Z     out  8     lane Z bits of head entry (debug/branch assist)
// BEHAVIOUR
//  Reset (i_RST=1 at edge): FIFO empty, count=0, rd/wr ptr=0, o_WB_VALID=0, o_READY=1,
//   o_GE=8'h00, o_Q=0; o_WB_DATA/o_WB_RD/o_LANE_Z=0 while empty. Reset beats all inputs,
//   including a handshake in the same cycle; mid-operation reset drops entries w/o commit.
//  Push = i_VALID & o_READY. Pop = o_WB_VALID & i_WB_READY. Entry = {RES,FLAGS,RD,FLAG_UPD}.
//  Latency: pushed entry appears on o_WB_* the cycle after push (no comb pass-through).
//  o_READY = (count != DEPTH); registered-derived, no comb path from i_WB_READY.
//  o_WB_VALID = (count != 0). o_WB_* reflect head entry; stable while valid & !ready.
//  Simultaneous push & pop: count unchanged, both ptrs advance. Full + pop: no push that
//   cycle (o_READY already 0). Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  Upstream must hold i_* stable while i_VALID & !o_READY; i_VALID need not wait on ready.
//  Commit (pop with head FLAG_UPD=1): GE[k] <= FLAGS[4k+1];
//   Q_next = (Q & ~i_Q_CLR) | (|{FLAGS[28],FLAGS[24],...,FLAGS[0]}). Pop with FLAG_UPD=0
//   leaves GE unchanged, Q_next = Q & ~i_Q_CLR. Set wins over clear in same cycle.
//  o_LANE_Z[k] = head FLAGS[4k+2].
//  i_FLUSH (sync): count<=0, ptrs<=0; same-cycle push dropped. Same-cycle pop still
//   commits (reg write and GE/Q update occur) since head was presented; others discarded.
//   Flushed entries never touch GE/Q. Reset has priority over flush.
//  No arithmetic on data: results/flags stored bit-exact.
// TESTING
//  1 Reset then push RES=32'h1234_5678, RD=3, WB_READY=1 -> next cycle o_WB_VALID=1,
//    o_WB_DATA=32'h1234_5678, o_WB_RD=3; following cycle o_WB_VALID=0.
//  2 WB_READY=0, push DEPTH=2 entries A,B -> o_READY=0 after 2nd; 3rd push held; release
//    ready -> A then B then held C committed in order, no loss/duplication.
//  3 Commit FLAGS=32'h2222_2222, FLAG_UPD=1 -> o_GE=8'hFF, o_Q=0; commit FLAGS=32'h0000_0001
//    -> o_GE=8'h00, o_Q=1; commit with FLAG_UPD=0 -> GE/Q unchanged; assert i_Q_CLR -> o_Q=0.
//  4 i_Q_CLR in same cycle as commit with lane V=1 -> o_Q=1 next cycle (set wins).
//  5 Two entries buffered, i_FLUSH with concurrent push and pop -> head commits, buffered
//    second and pushed entry dropped, count=0, GE/Q reflect only head.
//  6 i_RST asserted while full with push+pop pending -> next cycle empty, o_READY=1,
//    o_GE=0, o_Q=0, no commit observed; random push/pop soak vs. reference queue model.

Source files
------------

// File: rtl/micro_simd_wb_stage.sv
// Writeback/commit stage behind the 8-lane x 4-bit micro-SIMD ALU: a small result FIFO
// feeding the low register-file write port, plus sticky per-lane GE and saturation Q.
module micro_simd_wb_stage #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 3
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_VALID,
  output logic            o_READY,
  input  logic [31:0]     i_RES,
  input  logic [31:0]     i_FLAGS,
  input  logic [RD_W-1:0] i_RD,
  input  logic            i_FLAG_UPD,
  input  logic            i_FLUSH,
  input  logic            i_Q_CLR,
  output logic            o_WB_VALID,
  input  logic            i_WB_READY,
  output logic [31:0]     o_WB_DATA,
  output logic [RD_W-1:0] o_WB_RD,
  output logic [7:0]      o_GE,
  output logic            o_Q,
  output logic [7:0]      o_LANE_Z
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]     res_mem   [DEPTH];
  logic [31:0]     flags_mem [DEPTH];
  logic [RD_W-1:0] rd_mem    [DEPTH];
  logic [DEPTH-1:0] upd_mem;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    ge;
  logic          q;

  logic          push;
  logic          pop;
  logic          head_upd;
  logic [31:0]   head_flags;
  logic [7:0]    ge_commit;
  logic          v_any;

  assign o_READY    = (count != FULL_CNT);
  assign o_WB_VALID = (count != '0);
  assign push       = i_VALID & o_READY;
  assign pop        = o_WB_VALID & i_WB_READY;

  // Head outputs are forced to zero while empty so stale storage never leaks out.
  assign o_WB_DATA  = o_WB_VALID ? res_mem[rd_ptr]   : '0;
  assign o_WB_RD    = o_WB_VALID ? rd_mem[rd_ptr]    : '0;
  assign head_flags = o_WB_VALID ? flags_mem[rd_ptr] : '0;
  assign head_upd   = o_WB_VALID & upd_mem[rd_ptr];
  assign o_GE       = ge;
  assign o_Q        = q;

  always_comb begin
    ge_commit = '0;
    o_LANE_Z  = '0;
    v_any     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ge_commit[k] = head_flags[4*k+1];
      o_LANE_Z[k]  = head_flags[4*k+2];
      v_any        = v_any | head_flags[4*k];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (push && !i_FLUSH && !i_RST) begin
      res_mem[wr_ptr]   <= i_RES;
      flags_mem[wr_ptr] <= i_FLAGS;
      rd_mem[wr_ptr]    <= i_RD;
      upd_mem[wr_ptr]   <= i_FLAG_UPD;
    end
  end

  // A flush still lets the presented head commit; only the buffered remainder is lost.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ge     <= '0;
      q      <= 1'b0;
    end else begin
      if (i_FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (pop && head_upd) ge <= ge_commit;
      q <= (q & ~i_Q_CLR) | (pop & head_upd & v_any);
    end
  end

endmodule

// File: tb/tb_micro_simd_wb_stage.sv
// Bench for micro_simd_wb_stage: directed literal checks plus a random soak against a
// queue-based reference model compared on every falling edge.
module tb_micro_simd_wb_stage;

  localparam int DEPTH = 2;
  localparam int RD_W  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [31:0]     res;
  logic [31:0]     flags;
  logic [RD_W-1:0] rd;
  logic            flag_upd;
  logic            flush;
  logic            q_clr;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic [7:0]      ge;
  logic            q;
  logic [7:0]      lane_z;

  int tests = 0;
  int fails = 0;

  micro_simd_wb_stage #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALID(valid), .o_READY(ready),
    .i_RES(res), .i_FLAGS(flags), .i_RD(rd), .i_FLAG_UPD(flag_upd),
    .i_FLUSH(flush), .i_Q_CLR(q_clr), .o_WB_VALID(wb_valid), .i_WB_READY(wb_ready),
    .o_WB_DATA(wb_data), .o_WB_RD(wb_rd), .o_GE(ge), .o_Q(q), .o_LANE_Z(lane_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     res;
    logic [31:0]     flags;
    logic [RD_W-1:0] rd;
    logic            upd;
  } entry_t;

  entry_t     mq[$];
  logic [7:0] m_ge = 8'h00;
  logic       m_q = 1'b0;
  bit         model_live = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of entries, popped/pushed according to the handshake rules.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ge = 8'h00;
      m_q = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      bit do_push;
      bit do_pop;
      do_push = valid && (mq.size() < DEPTH);
      do_pop  = wb_ready && (mq.size() > 0);
      m_q = m_q & ~q_clr;
      if (do_pop && mq[0].upd) begin
        for (int k = 0; k < 8; k++) begin
          m_ge[k] = mq[0].flags[4*k+1];
          if (mq[0].flags[4*k]) m_q = 1'b1;
        end
      end
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{res: res, flags: flags, rd: rd, upd: flag_upd});
      end
    end
  end

  always @(negedge clk) begin
    if (model_live && !rst) begin
      logic [31:0] e_data;
      logic [31:0] e_flags;
      logic [7:0]  e_z;
      e_data  = (mq.size() > 0) ? mq[0].res : 32'h0;
      e_flags = (mq.size() > 0) ? mq[0].flags : 32'h0;
      for (int k = 0; k < 8; k++) e_z[k] = e_flags[4*k+2];
      checkOutput("model_wb_valid", {31'b0, wb_valid}, {31'b0, mq.size() > 0});
      checkOutput("model_ready", {31'b0, ready}, {31'b0, mq.size() < DEPTH});
      checkOutput("model_wb_data", wb_data, e_data);
      checkOutput("model_wb_rd", {29'b0, wb_rd}, (mq.size() > 0) ? {29'b0, mq[0].rd} : 32'h0);
      checkOutput("model_lane_z", {24'b0, lane_z}, {24'b0, e_z});
      checkOutput("model_ge", {24'b0, ge}, {24'b0, m_ge});
      checkOutput("model_q", {31'b0, q}, {31'b0, m_q});
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [31:0] f,
                               input logic [RD_W-1:0] d, input logic u, input logic wbr,
                               input logic fl, input logic qc);
    valid = v; res = r; flags = f; rd = d; flag_upd = u;
    wb_ready = wbr; flush = fl; q_clr = qc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_wb_valid", {31'b0, wb_valid}, 0);
    checkOutput("reset_ready", {31'b0, ready}, 1);
    checkOutput("reset_ge", {24'b0, ge}, 0);
    checkOutput("reset_q", {31'b0, q}, 0);
    checkOutput("reset_data", wb_data, 0);

    // single push, one-cycle latency, then commit
    applyStimulus(1, 32'h1234_5678, 0, 3, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_valid", {31'b0, wb_valid}, 1);
    checkOutput("t1_data", wb_data, 32'h1234_5678);
    checkOutput("t1_rd", {29'b0, wb_rd}, 3);
    tick();
    checkOutput("t1_drained", {31'b0, wb_valid}, 0);

    // fill, hold a third, then drain in order
    applyStimulus(1, 32'hAAAA_0001, 0, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'hBBBB_0002, 0, 2, 0, 0, 0, 0);
    tick();
    checkOutput("t2_full_ready", {31'b0, ready}, 0);
    applyStimulus(1, 32'hCCCC_0003, 0, 5, 0, 0, 0, 0);
    tick();
    checkOutput("t2_head_a", wb_data, 32'hAAAA_0001);
    applyStimulus(1, 32'hCCCC_0003, 0, 5, 0, 1, 0, 0);
    tick();
    checkOutput("t2_head_b", wb_data, 32'hBBBB_0002);
    tick();
    checkOutput("t2_head_c", wb_data, 32'hCCCC_0003);
    checkOutput("t2_rd_c", {29'b0, wb_rd}, 5);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("t2_empty", {31'b0, wb_valid}, 0);

    // sticky GE / Q
    applyStimulus(1, 32'h1, 32'h2222_2222, 1, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("t3_ge_ff", {24'b0, ge}, 32'hFF);
    checkOutput("t3_q0", {31'b0, q}, 0);
    applyStimulus(1, 32'h2, 32'h0000_0001, 1, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("t3_ge_00", {24'b0, ge}, 0);
    checkOutput("t3_q1", {31'b0, q}, 1);
    applyStimulus(1, 32'h3, 32'hFFFF_FFFF, 1, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("t3_noupd_ge", {24'b0, ge}, 0);
    checkOutput("t3_noupd_q", {31'b0, q}, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    checkOutput("t3_qclr", {31'b0, q}, 0);

    // set beats clear
    applyStimulus(1, 32'h4, 32'h0000_0010, 1, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    checkOutput("t4_set_wins", {31'b0, q}, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t4_cleared", {31'b0, q}, 0);

    // flush with concurrent push and pop: only head commits
    applyStimulus(1, 32'h5, 32'h0000_0002, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h6, 32'h3333_3333, 2, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h7, 32'h3333_3333, 3, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t5_empty", {31'b0, wb_valid}, 0);
    checkOutput("t5_ready", {31'b0, ready}, 1);
    checkOutput("t5_ge", {24'b0, ge}, 32'h01);
    checkOutput("t5_q", {31'b0, q}, 0);
    tick();
    checkOutput("t5_still_empty", {31'b0, wb_valid}, 0);

    // reset while full with push+pop pending
    applyStimulus(1, 32'h8, 32'h3333_3333, 4, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h9, 32'h3333_3333, 6, 1, 0, 0, 0);
    tick();
    checkOutput("t6_full", {31'b0, ready}, 0);
    rst = 1'b1;
    applyStimulus(1, 32'hA, 32'h3333_3333, 7, 1, 1, 0, 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t6_valid", {31'b0, wb_valid}, 0);
    checkOutput("t6_ready", {31'b0, ready}, 1);
    checkOutput("t6_ge", {24'b0, ge}, 0);
    checkOutput("t6_q", {31'b0, q}, 0);
    tick();
    checkOutput("t6_no_commit", {24'b0, ge}, 0);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      applyStimulus($urandom_range(2) != 0, $urandom, $urandom, RD_W'($urandom),
                    $urandom_range(1) == 1, $urandom_range(2) != 0,
                    $urandom_range(31) == 0, $urandom_range(7) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
